if_id_pipe_reg: RTL and testbench

Parametrised IF/ID pipeline register with a valid/ready handshake, synchronous flush and a 2-entry skid buffer.
- Carries the fetched instruction and its PC from the fetch stage to decode.
- Decode backpressure (load-use stall, multicycle op) stalls the pipeline without losing the fetch already in flight.
- Branch/jump redirect flushes the register; decode then sees a NOP bubble.

---
 rtl/if_id_pipe_reg.sv | 101 ++++++++++
 tb/tb_if_id_pipe_reg.sv | 110 +++++++++++
 2 files changed

// File: rtl/if_id_pipe_reg.sv
// if_id_pipe_reg: IF/ID pipeline register with valid/ready handshake, flush and 2-entry skid buffer.
// Optional stall counter enabled by defining IF_ID_STALL_CNT_EN.
module if_id_pipe_reg #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] NOP_INST = 32'h00000013
`ifdef IF_ID_STALL_CNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inst,
  input  logic [WIDTH-1:0] pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] inst_out,
  output logic [WIDTH-1:0] pc_out
`ifdef IF_ID_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);
  logic             main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] main_inst_q, main_inst_d, main_pc_q, main_pc_d;
  logic [WIDTH-1:0] skid_inst_q, skid_inst_d, skid_pc_q, skid_pc_d;
  logic             accept, consume;
  assign in_ready  = !skid_valid_q;
  assign out_valid = main_valid_q;
  assign inst_out  = main_inst_q;
  assign pc_out    = main_pc_q;
  assign accept    = in_valid & in_ready;
  assign consume   = main_valid_q & out_ready;
  // Main data is reloaded with NOP/0 whenever it goes invalid, so outputs are forced from flops.
  always_comb begin
    main_valid_d = main_valid_q;
    main_inst_d  = main_inst_q;
    main_pc_d    = main_pc_q;
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;
    if (flush) begin
      main_valid_d = 1'b0;
      main_inst_d  = NOP_INST;
      main_pc_d    = '0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (consume) begin
        main_inst_d  = skid_inst_q;
        main_pc_d    = skid_pc_q;
        skid_valid_d = 1'b0;
      end
    end else if (main_valid_q) begin
      if (accept && consume) begin
        main_inst_d = inst;
        main_pc_d   = pc;
      end else if (accept) begin
        skid_valid_d = 1'b1;
        skid_inst_d  = inst;
        skid_pc_d    = pc;
      end else if (consume) begin
        main_valid_d = 1'b0;
        main_inst_d  = NOP_INST;
        main_pc_d    = '0;
      end
    end else if (accept) begin
      main_valid_d = 1'b1;
      main_inst_d  = inst;
      main_pc_d    = pc;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_inst_q  <= NOP_INST;
      main_pc_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_inst_q  <= '0;
      skid_pc_q    <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_inst_q  <= main_inst_d;
      main_pc_q    <= main_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc_q    <= skid_pc_d;
    end
  end
`ifdef IF_ID_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  assign stall_cnt = stall_cnt_q;
  always_comb stall_cnt_d = (main_valid_q && !out_ready && !flush && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else stall_cnt_q <= stall_cnt_d;
  end
`endif
endmodule

// File: tb/tb_if_id_pipe_reg.sv
// tb_if_id_pipe_reg: directed and random stimulus checked against a queue-based model.
module tb_if_id_pipe_reg;
  localparam logic [31:0] NOP = 32'h00000013;
  logic        clk = 1'b0, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] inst, pc, inst_out, pc_out;
  logic [63:0] mq[$];
  int          total = 0, fails = 0, mcnt = 0;
`ifdef IF_ID_STALL_CNT_EN
  logic [3:0]  stall_cnt;
`endif
  if_id_pipe_reg #(
    .WIDTH(32),
    .NOP_INST(NOP)
`ifdef IF_ID_STALL_CNT_EN
    ,
    .CNT_W(4)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .inst(inst),
    .pc(pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .inst_out(inst_out),
    .pc_out(pc_out)
`ifdef IF_ID_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check();
    logic v;
    v = mq.size() > 0;
    chk("out_valid", {31'b0, out_valid}, {31'b0, v});
    chk("in_ready", {31'b0, in_ready}, {31'b0, mq.size() < 2});
    chk("inst_out", inst_out, v ? mq[0][63:32] : NOP);
    chk("pc_out", pc_out, v ? mq[0][31:0] : 32'h0);
`ifdef IF_ID_STALL_CNT_EN
    chk("stall_cnt", {28'b0, stall_cnt}, mcnt);
`endif
  endtask
  task automatic cyc(input logic r, input logic f, input logic iv, input logic [31:0] i,
                     input logic [31:0] p, input logic o);
    logic acc, cons;
    rst = r; flush = f; in_valid = iv; inst = i; pc = p; out_ready = o;
    acc  = iv && mq.size() < 2;
    cons = mq.size() > 0 && o;
    if (r) mcnt = 0;
    else if (!f && mq.size() > 0 && !o && mcnt < 15) mcnt++;
    if (r || f) mq.delete();
    else begin
      if (cons) void'(mq.pop_front());
      if (acc) mq.push_back({i, p});
    end
    @(posedge clk);
    @(negedge clk);
    check();
  endtask
  initial begin
    rst = 1; flush = 0; in_valid = 0; inst = 0; pc = 0; out_ready = 0;
    cyc(1, 0, 1, 32'hDEADBEEF, 32'h0, 0);
    cyc(1, 0, 1, 32'hDEADBEEF, 32'h0, 0);
    cyc(0, 0, 0, 32'h0, 32'h0, 1);
    // streaming
    for (int k = 0; k < 3; k++) cyc(0, 0, 1, 32'hA0 + k, 32'h4 * k, 1);
    cyc(0, 0, 0, 32'h0, 32'h0, 1);
    // skid
    cyc(0, 0, 1, 32'hB0, 32'h100, 1);
    cyc(0, 0, 1, 32'hB1, 32'h104, 0);
    cyc(0, 0, 1, 32'hB2, 32'h108, 0);
    cyc(0, 0, 1, 32'hB2, 32'h108, 1);
    cyc(0, 0, 1, 32'hB2, 32'h108, 1);
    cyc(0, 0, 0, 32'h0, 32'h0, 1);
    cyc(0, 0, 0, 32'h0, 32'h0, 1);
    // flush in SKID
    cyc(0, 0, 1, 32'hC0, 32'h200, 0);
    cyc(0, 0, 1, 32'hC1, 32'h204, 0);
    cyc(0, 1, 1, 32'hC2, 32'h208, 0);
    cyc(0, 0, 0, 32'h0, 32'h0, 1);
    // simultaneous events
    cyc(0, 0, 1, 32'hD0, 32'h300, 1);
    cyc(1, 1, 1, 32'hD1, 32'h304, 1);
    cyc(0, 0, 1, 32'hD2, 32'h308, 1);
    cyc(0, 1, 0, 32'h0, 32'h0, 1);
    // random traffic
    for (int k = 0; k < 400; k++)
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
          $urandom, $urandom, $urandom_range(0, 2) != 0);
    // stall saturation, flush keeps the count, rst clears it
    cyc(1, 0, 0, 32'h0, 32'h0, 0);
    cyc(0, 0, 1, 32'hE0, 32'h400, 0);
    for (int k = 0; k < 20; k++) cyc(0, 0, 0, 32'h0, 32'h0, 0);
    cyc(0, 1, 0, 32'h0, 32'h0, 0);
    cyc(1, 0, 0, 32'h0, 32'h0, 0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
